// File: rtl/uw_insert_rot_if.sv
// Bundle of the symbol-stream handshake signals between the unique-word
// inserter and its payload source / downstream transmitter.
interface uw_insert_rot_if #(
    parameter int INPUT_SIZE = 8
);
    logic                         start;
    logic [1:0]                   rot;
    logic signed [INPUT_SIZE-1:0] soft_in_0;
    logic signed [INPUT_SIZE-1:0] soft_in_1;
    logic                         valid_in;
    logic                         ready_in;
    logic signed [INPUT_SIZE-1:0] soft_out;
    logic                         valid_out;
    logic                         ready_tx;
    logic                         new_frameset;
    logic                         last_data;
    logic                         busy;

    modport master (
        output start, rot, soft_in_0, soft_in_1, valid_in, ready_tx,
        input  ready_in, soft_out, valid_out, new_frameset, last_data, busy
    );

    modport slave (
        input  start, rot, soft_in_0, soft_in_1, valid_in, ready_tx,
        output ready_in, soft_out, valid_out, new_frameset, last_data, busy
    );
endinterface

// File: rtl/uw_insert_rot.sv
// Prefixes every frame with an 8-symbol unique word and serialises I/Q pairs,
// imposing a selectable 0/90/180/270 degree phase rotation on UW and payload.
module uw_insert_rot #(
    parameter int         INPUT_SIZE     = 8,
    parameter int         BITS_PER_FRAME = 80,
    parameter int         NUM_FRAMES     = 32,
    parameter logic [7:0] UW_WORD        = 8'h27,
    parameter int         SOFT_MAG       = 127
) (
    input  logic            clk,
    input  logic            rst_in,
    uw_insert_rot_if.slave  bus
);
    localparam int SW = $clog2(BITS_PER_FRAME);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    localparam logic [SW-1:0] UW_LEN        = SW'(8);
    localparam logic [SW-1:0] SYM_LAST_PAIR = SW'(BITS_PER_FRAME - 2);
    localparam logic [FW-1:0] FRAME_LAST    = FW'(NUM_FRAMES - 1);

    localparam logic signed [INPUT_SIZE-1:0] S_MAX  = {1'b0, {(INPUT_SIZE-1){1'b1}}};
    localparam logic signed [INPUT_SIZE-1:0] S_MIN  = {1'b1, {(INPUT_SIZE-1){1'b0}}};
    localparam logic signed [INPUT_SIZE-1:0] UW_POS = INPUT_SIZE'(SOFT_MAG);
    localparam logic signed [INPUT_SIZE-1:0] UW_NEG = -UW_POS;

    typedef enum logic [1:0] {IDLE, LOAD, SEND_I, SEND_Q} state_t;

    state_t                       state, state_next;
    logic [1:0]                   rot_lat;
    logic [SW-1:0]                sym_cnt;
    logic [FW-1:0]                frame_cnt;
    logic signed [INPUT_SIZE-1:0] q_hold, soft_out_r;
    logic signed [INPUT_SIZE-1:0] raw_i, raw_q, rot_i, rot_q;
    logic                         valid_out_r, new_frameset_r, last_data_r;
    logic                         uw_region, last_pair, take_pair, ready_in_c;
    logic [2:0]                   uw_bit;

    // Two's-complement negation of the most negative code would wrap; clamp it.
    function automatic logic signed [INPUT_SIZE-1:0] neg_sat(input logic signed [INPUT_SIZE-1:0] x);
        return (x == S_MIN) ? S_MAX : -x;
    endfunction

    assign uw_region = (sym_cnt < UW_LEN);
    assign last_pair = (sym_cnt == SYM_LAST_PAIR) && (frame_cnt == FRAME_LAST);
    assign uw_bit    = 3'd7 - sym_cnt[2:0];

    always_comb begin
        raw_i = bus.soft_in_0;
        raw_q = bus.soft_in_1;
        if (uw_region) begin
            raw_i = UW_WORD[uw_bit]        ? UW_POS : UW_NEG;
            raw_q = UW_WORD[uw_bit - 3'd1] ? UW_POS : UW_NEG;
        end
        rot_i = raw_i;
        rot_q = raw_q;
        case (rot_lat)
            2'd1: begin rot_i = neg_sat(raw_q); rot_q = raw_i;          end
            2'd2: begin rot_i = neg_sat(raw_i); rot_q = neg_sat(raw_q); end
            2'd3: begin rot_i = raw_q;          rot_q = neg_sat(raw_i); end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        take_pair  = 1'b0;
        ready_in_c = 1'b0;
        case (state)
            IDLE:   if (bus.start) state_next = LOAD;
            LOAD: begin
                ready_in_c = !uw_region;
                if (uw_region || bus.valid_in) begin
                    take_pair  = 1'b1;
                    state_next = SEND_I;
                end
            end
            SEND_I: if (bus.ready_tx) state_next = SEND_Q;
            SEND_Q: if (bus.ready_tx) state_next = last_pair ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            rot_lat        <= 2'd0;
            sym_cnt        <= '0;
            frame_cnt      <= '0;
            q_hold         <= '0;
            soft_out_r     <= '0;
            valid_out_r    <= 1'b0;
            new_frameset_r <= 1'b0;
            last_data_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    rot_lat   <= bus.rot;
                    sym_cnt   <= '0;
                    frame_cnt <= '0;
                end
                LOAD: if (take_pair) begin
                    soft_out_r     <= rot_i;
                    q_hold         <= rot_q;
                    valid_out_r    <= 1'b1;
                    new_frameset_r <= (sym_cnt == '0) && (frame_cnt == '0);
                    last_data_r    <= 1'b0;
                end
                SEND_I: if (bus.ready_tx) begin
                    soft_out_r     <= q_hold;
                    new_frameset_r <= 1'b0;
                    last_data_r    <= last_pair;
                end
                SEND_Q: if (bus.ready_tx) begin
                    valid_out_r <= 1'b0;
                    last_data_r <= 1'b0;
                    if (sym_cnt == SYM_LAST_PAIR) begin
                        sym_cnt   <= '0;
                        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
                    end else begin
                        sym_cnt <= sym_cnt + SW'(2);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_in     = ready_in_c;
    assign bus.soft_out     = soft_out_r;
    assign bus.valid_out    = valid_out_r;
    assign bus.new_frameset = new_frameset_r;
    assign bus.last_data    = last_data_r;
    assign bus.busy         = (state != IDLE);
endmodule
